spi_reg_ctrl: RTL and testbench

- Command/register controller that sequences the SPI slave byte datapath.
- Consumes received bytes and their 1-cycle strobe, decodes a command byte, then either writes or reads fabric registers with address auto-increment.
- Drives the slave's transmit byte and sits between the SPI slave and the fabric register bus.

---
 rtl/spi_reg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// Command/register sequencer between an SPI slave byte datapath and a fabric register bus.
// Define SPI_REG_CTRL_STATUS_EN to add a frame counter reported as a status byte during the command byte.
module spi_reg_ctrl #(
  parameter int         ADDR_W  = 7,
  parameter logic [7:0] IDLE_TX = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        rxd_out,
  input  logic              rxd_flag,
  output logic [7:0]        txd_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WR       = 3'd2,
    RD_FETCH = 3'd3,
    RD_LATCH = 3'd4,
    RD_DATA  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              cs_s1_q, cs_s1_d;
  logic              cs_s2_q, cs_s2_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic [7:0]        txd_q, txd_d;
  logic              reg_we_q, reg_we_d;
  logic              rd_strobe;
  logic              frame_active;
  logic              frame_end;

  assign frame_active = ~cs_s2_q;
  assign frame_end    = (state_q != IDLE) && !frame_active;

  always_comb begin
    state_d     = state_q;
    cs_s1_d     = cs;
    cs_s2_d     = cs_s1_q;
    settle_d    = {settle_q[0], 1'b1};
    // A frame may only start after a genuine high on cs has passed the
    // synchronizer, so a reset released mid-frame cannot restart that frame.
    armed_d     = armed_q | (settle_q[1] & cs_s2_q);
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    txd_d       = txd_q;
    reg_we_d    = 1'b0;
    rd_strobe   = 1'b0;

    if (frame_end) begin
      state_d = IDLE;
      txd_d   = IDLE_TX;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_active && armed_q) state_d = CMD;
        end
        CMD: begin
          if (rxd_flag) begin
            addr_d     = rxd_out[ADDR_W-1:0];
            reg_addr_d = rxd_out[ADDR_W-1:0];
            state_d    = rxd_out[7] ? RD_FETCH : WR;
          end
        end
        WR: begin
          if (rxd_flag) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = rxd_out;
            addr_d      = addr_q + ADDR_W'(1);
          end
        end
        RD_FETCH: begin
          rd_strobe = 1'b1;
          state_d   = RD_LATCH;
        end
        RD_LATCH: begin
          txd_d   = reg_rdata;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD_DATA;
        end
        RD_DATA: begin
          if (rxd_flag) begin
            reg_addr_d = addr_q;
            state_d    = RD_FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      txd_q       <= IDLE_TX;
      reg_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_s1_q     <= cs_s1_d;
      cs_s2_q     <= cs_s2_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      txd_q       <= txd_d;
      reg_we_q    <= reg_we_d;
    end
  end

`ifdef SPI_REG_CTRL_STATUS_EN
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       got_byte_q, got_byte_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    got_byte_d  = got_byte_q;
    if (frame_end) begin
      if (got_byte_q) frame_cnt_d = frame_cnt_q + 4'd1;
      got_byte_d = 1'b0;
    end else if (rxd_flag && (state_q == CMD || state_q == WR || state_q == RD_DATA)) begin
      got_byte_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= 4'd0;
      got_byte_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      got_byte_q  <= got_byte_d;
    end
  end

  assign txd_data = (state_q == IDLE || state_q == CMD) ? {4'hA, frame_cnt_q} : txd_q;
`else
  assign txd_data = txd_q;
`endif

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = rd_strobe;
  assign busy      = frame_active;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus pushes expected bus accesses and shifted-out bytes,
// a monitor pops and compares them as the DUT presents them.
module tb_spi_reg_ctrl;
  localparam int         ADDR_W  = 7;
  localparam logic [7:0] IDLE_TX = 8'h00;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs;
  logic [7:0]        rxd_out;
  logic              rxd_flag;
  logic [7:0]        txd_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .IDLE_TX(IDLE_TX)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .rxd_out  (rxd_out),
    .rxd_flag (rxd_flag),
    .txd_data (txd_data),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [14:0] exp_wr_q[$];
  logic [6:0]  exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  ref_mem[128];
  logic [3:0]  frame_cnt = 4'd0;
  bit          mon_en    = 1'b0;

  // Register bus slave: unwritten locations read back as address ^ 0xFF.
  logic [7:0] bus_mem[128];
  bit         bus_wr[128];
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= bus_wr[reg_addr] ? bus_mem[reg_addr] : ({1'b0, reg_addr} ^ 8'hFF);
    if (reg_we) begin
      bus_mem[reg_addr] <= reg_wdata;
      bus_wr[reg_addr]  <= 1'b1;
    end
  end

  function automatic logic [7:0] idle_byte();
`ifdef SPI_REG_CTRL_STATUS_EN
    return {4'hA, frame_cnt};
`else
    return IDLE_TX;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every bus access and every exchanged byte against the queues.
  initial begin
    logic [14:0] ew;
    logic [6:0]  er;
    logic [7:0]  et;
    bit          pwe;
    bit          pre;
    pwe = 1'b0;
    pre = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (reg_we || reg_re) chk("we_re_exclusive", 32'(reg_we & reg_re), 32'd0);
        if (reg_we) begin
          chk("we_single_pulse", 32'(pwe), 32'd0);
          if (exp_wr_q.size() == 0) chk("unexpected_reg_we", 32'd1, 32'd0);
          else begin
            ew = exp_wr_q.pop_front();
            chk("wr_addr", 32'(reg_addr), 32'(ew[14:8]));
            chk("wr_data", 32'(reg_wdata), 32'(ew[7:0]));
          end
        end
        if (reg_re) begin
          chk("re_single_pulse", 32'(pre), 32'd0);
          if (exp_rd_q.size() == 0) chk("unexpected_reg_re", 32'd1, 32'd0);
          else begin
            er = exp_rd_q.pop_front();
            chk("rd_addr", 32'(reg_addr), 32'(er));
          end
        end
        if (rxd_flag) begin
          if (exp_tx_q.size() == 0) chk("unexpected_rxd_flag", 32'd1, 32'd0);
          else begin
            et = exp_tx_q.pop_front();
            chk("tx_byte", 32'(txd_data), 32'(et));
          end
        end
        pwe = reg_we;
        pre = reg_re;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic flag_byte(input logic [7:0] b, input logic [7:0] exp_tx);
    exp_tx_q.push_back(exp_tx);
    rxd_out  = b;
    rxd_flag = 1'b1;
    step();
    rxd_flag = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_tx);
    flag_byte(b, exp_tx);
    steps(3);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    steps(4);
    chk("busy_on", 32'(busy), 32'd1);
    chk("tx_status", 32'(txd_data), 32'(idle_byte()));
  endtask

  task automatic end_frame(input bit accepted);
    cs = 1'b1;
    steps(4);
    if (accepted) frame_cnt = frame_cnt + 4'd1;
    chk("busy_off", 32'(busy), 32'd0);
    chk("tx_idle", 32'(txd_data), 32'(idle_byte()));
  endtask

  task automatic write_frame(input logic [6:0] addr, input int n, input bit directed);
    logic [6:0] a;
    logic [7:0] d;
    start_frame();
    send_byte({1'b0, addr}, idle_byte());
    a = addr;
    for (int k = 0; k < n; k++) begin
      d = directed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
      exp_wr_q.push_back({a, d});
      ref_mem[a] = d;
      send_byte(d, IDLE_TX);
      a = a + 7'd1;
    end
    end_frame(1'b1);
  endtask

  task automatic read_frame(input logic [6:0] addr, input int n);
    logic [6:0] a;
    logic [6:0] na;
    start_frame();
    a = addr;
    exp_rd_q.push_back(a);
    flag_byte({1'b1, addr}, idle_byte());
    step();
    chk("rd_latency_early", 32'(txd_data), 32'(IDLE_TX));
    step();
    chk("rd_latency_3", 32'(txd_data), 32'(ref_mem[a]));
    step();
    for (int k = 0; k < n; k++) begin
      na = a + 7'd1;
      exp_rd_q.push_back(na);
      flag_byte(8'($urandom), ref_mem[a]);
      a = na;
      steps(3);
    end
    end_frame(1'b1);
  endtask

  // cs end and a data flag land in the same synchronized cycle.
  task automatic abort_frame(input bit rw, input logic [6:0] addr);
    start_frame();
    if (rw) exp_rd_q.push_back(addr);
    flag_byte({rw, addr}, idle_byte());
    step();
    cs = 1'b1;
    step();
    step();
    flag_byte(8'($urandom), rw ? ref_mem[addr] : IDLE_TX);
    frame_cnt = frame_cnt + 4'd1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tx_idle", 32'(txd_data), 32'(idle_byte()));
    steps(3);
  endtask

  task automatic cmd_only_frame(input logic [6:0] addr);
    start_frame();
    send_byte({1'b0, addr}, idle_byte());
    end_frame(1'b1);
    send_byte(8'($urandom), idle_byte());
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_tx_idle", 32'(txd_data), 32'(idle_byte()));
  endtask

  initial begin
    int kind;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
    rst      = 1'b0;
    cs       = 1'b1;
    rxd_flag = 1'b0;
    rxd_out  = 8'h00;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cs = ~cs;
      step();
    end
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_re", 32'(reg_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txd", 32'(txd_data), 32'(idle_byte()));
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    cs  = 1'b1;
    rst = 1'b1;
    steps(4);

    write_frame(7'h05, 3, 1'b1);
    read_frame(7'h7E, 2);
    abort_frame(1'b1, 7'h20);
    abort_frame(1'b0, 7'h30);
    cmd_only_frame(7'h44);

    // Reset mid-frame: bytes after release are ignored until a fresh cs fall.
    start_frame();
    send_byte(8'h10, idle_byte());
    exp_wr_q.push_back({7'h10, 8'h5A});
    ref_mem[7'h10] = 8'h5A;
    send_byte(8'h5A, IDLE_TX);
    rst = 1'b0;
    step();
    rst = 1'b1;
    frame_cnt = 4'd0;
    steps(4);
    chk("post_rst_tx", 32'(txd_data), 32'(idle_byte()));
    send_byte(8'h11, idle_byte());
    send_byte(8'h22, idle_byte());
    cs = 1'b1;
    steps(4);
    chk("post_rst_tx_idle", 32'(txd_data), 32'(idle_byte()));

    write_frame(7'h10, 1, 1'b0);
    read_frame(7'h0F, 2);
    start_frame();
    cs = 1'b1;
    steps(4);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: write_frame(7'($urandom), $urandom_range(1, 4), 1'b0);
        1: read_frame(7'($urandom), $urandom_range(1, 3));
        2: abort_frame(1'($urandom), 7'($urandom));
        3: cmd_only_frame(7'($urandom));
        default: begin
          write_frame(7'($urandom_range(124, 127)), 4, 1'b0);
          read_frame(7'($urandom_range(125, 127)), 3);
        end
      endcase
    end

    steps(10);
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
